// File: rtl/vcop_issue_queue.sv
`timescale 1ns/1ps
// vcop_issue_queue: in-order DEPTH-entry issue queue with a single-flight dispatch/result FSM.
// Performance counters are built only when VCOP_ISSUE_STATS_EN is defined.
module vcop_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [31:0]           issue_instr_i,
    input  logic [X_ID_WIDTH-1:0] issue_id_i,
    input  logic [31:0]           issue_rs0_i,
    output logic                  issue_accept_o,
    output logic                  issue_loadstore_o,
    output logic                  issue_writeback_o,
    input  logic                  commit_valid_i,
    input  logic [X_ID_WIDTH-1:0] commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  disp_valid_o,
    input  logic                  disp_ready_i,
    output logic [1:0]            disp_kind_o,
    output logic [6:0]            disp_funct7_o,
    output logic [2:0]            disp_funct3_o,
    output logic [4:0]            disp_rd_o,
    output logic [4:0]            disp_rs1_o,
    output logic [4:0]            disp_rs2_o,
    output logic [31:0]           disp_addr_o,
    output logic [X_ID_WIDTH-1:0] disp_id_o,
    input  logic                  unit_done_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [X_ID_WIDTH-1:0] result_id_o,
    output logic                  result_we_o,
    output logic [31:0]           stat_issued_o,
    output logic [31:0]           stat_killed_o,
    output logic [31:0]           stat_stall_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [6:0] CUSTOM0_OPCODE = 7'h0B;
    localparam logic [6:0] F7_VLD   = 7'h01;
    localparam logic [6:0] F7_VST   = 7'h02;
    localparam logic [6:0] F7_VADD  = 7'h03;
    localparam logic [6:0] F7_VSUB  = 7'h04;
    localparam logic [6:0] F7_VMUL  = 7'h05;
    localparam logic [6:0] F7_VMAC  = 7'h06;
    localparam logic [6:0] F7_VMMUL = 7'h07;

    // state     | meaning
    // IDLE      | waiting for a resolved head entry; killed heads are dropped here
    // DISPATCH  | disp_valid_o high with head fields
    // WAIT_DONE | back-end executing, waiting for unit_done_i
    // RESULT    | result_valid_o high until the CPU takes it, then pop
    typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_DONE, RESULT} state_t;
    state_t state;

    logic [31:0]           instr_q [DEPTH];
    logic [31:0]           addr_q  [DEPTH];
    logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
    logic [1:0]            kind_q  [DEPTH];
    logic [DEPTH-1:0]      we_q, valid_q, committed_q, killed_q;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;

    logic [6:0] dec_f7;
    logic       dec_ok, dec_ld, dec_st;
    logic       push, pop, pop_kill, new_commit;

    assign dec_f7 = issue_instr_i[31:25];
    assign dec_ld = (dec_f7 == F7_VLD);
    assign dec_st = (dec_f7 == F7_VST);
    assign dec_ok = (issue_instr_i[6:0] == CUSTOM0_OPCODE) &&
                    (dec_f7 inside {F7_VLD, F7_VST, F7_VADD, F7_VSUB, F7_VMUL, F7_VMAC, F7_VMMUL});

    assign issue_ready_o     = !rst_i && (count != (PW+1)'(DEPTH));
    assign push              = issue_valid_i && issue_ready_o && dec_ok;
    assign issue_accept_o    = push;
    assign issue_loadstore_o = !rst_i && dec_ok && (dec_ld || dec_st);
    assign issue_writeback_o = !rst_i && dec_ok && !dec_st;

    assign pop_kill   = (state == IDLE) && valid_q[rd_ptr] && killed_q[rd_ptr];
    assign pop        = pop_kill || ((state == RESULT) && result_ready_i);
    assign new_commit = commit_valid_i && (commit_id_i == issue_id_i);

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_q[wr_ptr] <= issue_instr_i;
            addr_q[wr_ptr]  <= issue_rs0_i;
            id_q[wr_ptr]    <= issue_id_i;
            kind_q[wr_ptr]  <= dec_ld ? 2'd1 : (dec_st ? 2'd2 : 2'd0);
            we_q[wr_ptr]    <= !dec_st;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
        end else begin
            // Only unresolved entries react, so a late kill cannot touch an entry already in flight.
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && valid_q[i] && !committed_q[i] && !killed_q[i] &&
                    (id_q[i] == commit_id_i)) begin
                    if (commit_kill_i) killed_q[i]    <= 1'b1;
                    else               committed_q[i] <= 1'b1;
                end
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            if (push) begin
                valid_q[wr_ptr]     <= 1'b1;
                committed_q[wr_ptr] <= new_commit && !commit_kill_i;
                killed_q[wr_ptr]    <= new_commit && commit_kill_i;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            disp_valid_o   <= 1'b0;
            result_valid_o <= 1'b0;
            disp_kind_o    <= '0;
            disp_funct7_o  <= '0;
            disp_funct3_o  <= '0;
            disp_rd_o      <= '0;
            disp_rs1_o     <= '0;
            disp_rs2_o     <= '0;
            disp_addr_o    <= '0;
            disp_id_o      <= '0;
            result_id_o    <= '0;
            result_we_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_q[rd_ptr] && committed_q[rd_ptr] && !killed_q[rd_ptr]) begin
                        state         <= DISPATCH;
                        disp_valid_o  <= 1'b1;
                        disp_kind_o   <= kind_q[rd_ptr];
                        disp_funct7_o <= instr_q[rd_ptr][31:25];
                        disp_rs2_o    <= instr_q[rd_ptr][24:20];
                        disp_rs1_o    <= instr_q[rd_ptr][19:15];
                        disp_funct3_o <= instr_q[rd_ptr][14:12];
                        disp_rd_o     <= instr_q[rd_ptr][11:7];
                        disp_addr_o   <= addr_q[rd_ptr];
                        disp_id_o     <= id_q[rd_ptr];
                    end
                end
                DISPATCH: begin
                    if (disp_ready_i) begin
                        state        <= WAIT_DONE;
                        disp_valid_o <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (unit_done_i) begin
                        state          <= RESULT;
                        result_valid_o <= 1'b1;
                        result_id_o    <= id_q[rd_ptr];
                        result_we_o    <= we_q[rd_ptr];
                    end
                end
                RESULT: begin
                    if (result_ready_i) begin
                        state          <= IDLE;
                        result_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VCOP_ISSUE_STATS_EN
    logic [31:0] issued_cnt, killed_cnt, stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issued_cnt <= '0;
            killed_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (push)                            issued_cnt <= issued_cnt + 32'd1;
            if (pop_kill)                        killed_cnt <= killed_cnt + 32'd1;
            if (issue_valid_i && !issue_ready_o) stall_cnt  <= stall_cnt + 32'd1;
        end
    end

    assign stat_issued_o = issued_cnt;
    assign stat_killed_o = killed_cnt;
    assign stat_stall_o  = stall_cnt;
`else
    assign stat_issued_o = '0;
    assign stat_killed_o = '0;
    assign stat_stall_o  = '0;
`endif

endmodule

// File: doc/vcop_issue_queue.md
# vcop_issue_queue

Parametrised issue/dispatch controller for the vector coprocessor, replacing the single-instruction "accept only in IDLE" FSM. It sits between the CV32E40X X-interface (issue, commit, result) and the vector back-end (VLSU and vector execution unit). Instructions are buffered in a DEPTH-entry in-order queue while the back-end is busy. Dispatch waits for commit, and killed instructions are dropped without execution.

## Interface
- DEPTH, 4: queue entries; power of 2, ≥2
- X_ID_WIDTH, 4: XIF instruction id width
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- issue_valid_i  in  1  XIF issue request valid
- issue_ready_o  out  1  queue can take an issue
- issue_instr_i  in  32  instruction word
- issue_id_i  in  X_ID_WIDTH  instruction id
- issue_rs0_i  in  32  scalar rs1 value (base address)
- issue_accept_o  out  1  instruction is a supported vector op
- issue_loadstore_o  out  1  VLD or VST
- issue_writeback_o  out  1  VLD or exec op
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  X_ID_WIDTH  committed id
- commit_kill_i  in  1  kill instead of commit
- disp_valid_o  out  1  dispatch request to back-end
- disp_ready_i  in  1  back-end takes dispatch
- disp_kind_o  out  2  0 = exec, 1 = load, 2 = store
- disp_funct7_o / disp_funct3_o  out  7/3  operation fields
- disp_rd_o / disp_rs1_o / disp_rs2_o  out  5 each  register fields
- disp_addr_o  out  32  latched rs0 value
- disp_id_o  out  X_ID_WIDTH  id of dispatched entry
- unit_done_i  in  1  back-end completion pulse
- result_valid_o  out  1  XIF result valid
- result_ready_i  in  1  CPU takes result
- result_id_o  out  X_ID_WIDTH  id of result
- result_we_o  out  1  copy of entry writeback flag
- stat_issued_o / stat_killed_o / stat_stall_o  out  32 each  performance counters

## Operation
- Decode:
  - Supported op: opcode == CUSTOM0_OPCODE and funct7 ∈ {VLD, VST, VADD, VSUB, VMUL, VMAC, VMMUL} (custom_opcodes.vh).
  - issue_accept_o = issue_valid_i & issue_ready_o & supported.
  - loadstore and writeback are combinational from the decode.
- Enqueue:
  - Occurs on issue_valid_i & issue_ready_o & supported.
  - Stores instr fields, id, rs0, kind, we. The committed and killed flags are cleared.
  - A handshake with accept = 0 enqueues nothing.
- Full condition: issue_ready_o = !rst_i & (count != DEPTH). There is no same-cycle pop bypass.
- Commit:
  - commit_valid_i sets committed (or killed when commit_kill_i = 1) on every valid entry whose id matches and which is not yet committed.
  - This includes an entry being enqueued in the same cycle with the same id.
  - A commit with an unmatched id is ignored.
- Dispatch FSM (head entry only; one instruction in flight):
  - IDLE:
    - Head valid & killed → pop, no result, stay IDLE.
    - Head valid & committed & !killed → DISPATCH.
    - Otherwise stay IDLE.
  - DISPATCH: disp_valid_o = 1 with head fields. On disp_ready_i → WAIT_DONE.
  - WAIT_DONE: on unit_done_i → RESULT.
  - RESULT: result_valid_o = 1 with result_id_o and result_we_o. On result_ready_i → pop head, IDLE.
- A kill for an entry already in DISPATCH, WAIT_DONE or RESULT is ignored, because its commit has already happened.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Simultaneous enqueue and pop: count is unchanged, and both pointers advance.

## Timing
- Reset (synchronous, rst_i high at a clk_i edge):
  - Pointers, count, flags and counters are cleared; FSM returns to IDLE.
  - All outputs are 0: issue_ready_o is forced 0 while rst_i = 1, and becomes 1 on the first cycle after reset.
- Reset mid-operation discards all queued and in-flight entries and emits no result.
- An entry enqueued at edge N is visible at the head from cycle N+1.
- If the entry is already committed, disp_valid_o rises at cycle N+2 at the earliest.
- disp_* and result_* outputs hold stable while valid is high and ready is low.
- A killed head is popped in one cycle.
- unit_done_i outside WAIT_DONE is ignored.
- Minimum per-instruction occupancy: 4 cycles (IDLE → DISPATCH → WAIT_DONE → RESULT, each with zero-wait handshakes).

## Configuration
- VCOP_ISSUE_STATS_EN defined:
  - stat_issued_o increments per enqueue.
  - stat_killed_o increments per killed-head pop.
  - stat_stall_o increments each cycle with issue_valid_i & !issue_ready_o.
  - All counters wrap at 2^32.
- VCOP_ISSUE_STATS_EN undefined: the counters are not built, and the three stat ports are tied to 0.

## Test plan
- Reset then single VADD (id 3), committed in the same cycle as issue, done 5 cycles after dispatch → issue_accept_o = 1, disp_kind_o = 0; result_valid_o with result_id_o = 3, result_we_o = 1.
- Unsupported funct7 0x7F issued → issue_accept_o = 0, count stays 0, no dispatch.
- DEPTH = 4; issue 5 VLDs (ids 0–4) with back-end stalled (disp_ready_i = 0) → issue_ready_o = 0 after the 4th; the 5th is accepted only after the first result pops.
- Issue ids 1, 2, 3; kill id 2, commit ids 1 and 3 → dispatch and result order is 1, 3; id 2 produces no result; stat_killed_o = 1 with the macro defined.
- VST (id 5) committed, result_ready_i held low 10 cycles → result_valid_o, result_id_o = 5 and result_we_o = 0 stay stable for all 10 cycles; pop happens on the ready cycle.
- rst_i asserted during WAIT_DONE with 3 entries queued → next cycle count = 0, all outputs 0; issue_ready_o = 1 once rst_i is low.
